pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage pipeline.
- Drives write-enable and flush controls for the PC, IF/ID, ID/EX and EX/MEM registers.
- Resolves load-use hazards, taken branches resolved in EX, multi-cycle EX operations (mul/div) and data-memory wait states.
- Sits beside the pipeline registers; has no datapath of its own.

Parameters:
- REG_ADDR_W, 5, register-index width.
- FLUSH_CYCLES, 1, cycles IF/ID flush is held after a taken branch (1..4).
- MC_MAX_CYCLES, 64, watchdog limit for a multi-cycle op (>=2).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- id_valid  in  1  ID holds a real instruction.
- id_rs1, id_rs2  in  REG_ADDR_W  ID source registers.
- id_uses_rs1, id_uses_rs2  in  1  source operand actually read.
- ex_mem_read  in  1  EX instruction is a load.
- ex_rd  in  REG_ADDR_W  EX destination register.
- ex_branch_taken  in  1  EX resolved a taken branch/jump.
- ex_mc_start  in  1  EX issues a multi-cycle op (single-cycle pulse per op).
- mc_done  in  1  multi-cycle unit result ready.
- dmem_wait  in  1  data memory not ready; freeze pipeline.
- pc_write, if_id_write, id_ex_write  out  1  register enables.
- if_id_flush, id_ex_flush, ex_mem_flush  out  1  insert bubble.
- mc_timeout  out  1  sticky watchdog error.
- ctrl_state  out  2  current FSM state (debug).
- stall_cycles, flush_events  out  32  performance counters.

Behaviour:
- States: RUN=0, MC_WAIT=1, FLUSH=2. Only the FSM, the counters and mc_timeout are registered. Enable/flush outputs are combinational from the state and the current inputs, so there is zero-cycle reaction.
- Reset (asynchronous, active-high):
  - State returns to RUN.
  - Flush counter, watchdog counter, mc_timeout, stall_cycles and flush_events are cleared.
  - While reset is high, every enable and flush output is 0.
  - A reset during MC_WAIT or FLUSH aborts the operation immediately.
- Default in RUN: all writes 1, all flushes 0.
- Priority, highest first: dmem_wait > branch > multi-cycle > load-use.
- dmem_wait=1, any state:
  - All writes 0, all flushes 0.
  - State, flush counter and watchdog counter hold.
  - Branch, mc and load-use inputs are ignored; they re-evaluate when the wait drops, because EX is held.
- Taken branch, in RUN:
  - if_id_flush=1, id_ex_flush=1, pc_write=1 (loads the target).
  - If FLUSH_CYCLES>1: go to FLUSH with counter=FLUSH_CYCLES-1.
- FLUSH state:
  - if_id_flush=1, all other outputs at default.
  - Counter decrements each cycle; return to RUN the cycle it reaches 0 (the last flush cycle).
  - ex_branch_taken in FLUSH restarts the counter.
- Multi-cycle op: ex_mc_start in RUN, no branch, goes to MC_WAIT with watchdog=0.
  - In the start cycle and in MC_WAIT: pc_write, if_id_write and id_ex_write are 0; ex_mem_flush=1.
  - mc_done in MC_WAIT: that cycle all writes are 1 and flushes 0; next state RUN.
  - mc_done is ignored outside MC_WAIT.
  - Watchdog increments each MC_WAIT cycle. At MC_MAX_CYCLES-1 without mc_done: set mc_timeout (sticky until reset), release as if done, go to RUN.
- Load-use, in RUN:
  - Condition: ex_mem_read, ex_rd!=0, id_valid, and a match (id_uses_rs1 && id_rs1==ex_rd, or id_uses_rs2 && id_rs2==ex_rd).
  - Response: pc_write=0, if_id_write=0, id_ex_flush=1 for exactly one cycle. No state change.
  - Register 0 never hazards.
- Simultaneous events:
  - Branch and ex_mc_start: branch wins; mc_start is dropped.
  - Branch and load-use: branch wins; the ID instruction is flushed.
  - Load-use and mc_start: mc wins.

Optional Feature:
- PIPE_PERF_CNT_EN defined:
  - stall_cycles increments every cycle pc_write=0 while reset is low.
  - flush_events increments on each accepted taken branch.
  - Both counters wrap at 2^32.
- Undefined: both ports are tied to 0; no counter flops.

Decomposition:
- Package pipe_ctrl_pkg: state enum (RUN/MC_WAIT/FLUSH), REG_ADDR_W constant, 32-bit counter width constant.
- One sub-module: load_use_detect, purely combinational register-compare logic instantiated by the controller.

Test Plan:
- Load x5 in EX, ID uses rs2=x5 -> one cycle with pc_write=0, if_id_write=0, id_ex_flush=1; next cycle all writes 1.
- ex_branch_taken with FLUSH_CYCLES=3 -> if_id_flush high for 3 cycles, id_ex_flush only in the first; ctrl_state 0->2->2->0.
- ex_mc_start, mc_done 5 cycles later -> pc_write=0 for 6 cycles (start plus 5 wait), ex_mem_flush=1 in each, released in the done cycle.
- MC_MAX_CYCLES=8, no mc_done -> mc_timeout=1 after 8 stalled cycles, state RUN, flag stays 1 until reset.
- dmem_wait raised mid-MC_WAIT for 3 cycles, then load-use plus branch together -> watchdog frozen while waiting; branch wins, with if_id_flush=1, id_ex_flush=1, pc_write=1.
- Reset asserted during FLUSH, asynchronous between edges -> outputs 0 immediately; after release state RUN and counters 0 (PIPE_PERF_CNT_EN build).

Source files
------------

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Optional performance counters are enabled with the PIPE_PERF_CNT_EN macro.
package pipe_ctrl_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int CNT_W      = 32;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_MC_WAIT = 2'd1,
        ST_FLUSH   = 2'd2
    } ctrl_state_e;

endpackage

// File: rtl/pipeline_hazard_ctrl_load_use_detect.sv
// Combinational load-use comparator: flags an ID instruction that reads the
// destination of a load currently in EX. Register 0 never creates a hazard.
module load_use_detect #(
    parameter int REG_ADDR_W = pipe_ctrl_pkg::REG_ADDR_W
) (
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_uses_rs1,
    input  logic                  id_uses_rs2,
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    output logic                  hazard
);

    logic rs1_hit_s;
    logic rs2_hit_s;

    // Compare both source operands against the load destination
    always_comb begin
        rs1_hit_s = id_uses_rs1 && (id_rs1 == ex_rd);
        rs2_hit_s = id_uses_rs2 && (id_rs2 == ex_rd);
        hazard    = ex_mem_read && id_valid && (ex_rd != {REG_ADDR_W{1'b0}})
                    && (rs1_hit_s || rs2_hit_s);
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline. Enables and flushes are
// combinational from the state and current inputs; only the FSM, the flush
// and watchdog counters, the timeout flag and the optional performance
// counters (macro PIPE_PERF_CNT_EN) are registered.
module pipeline_hazard_ctrl #(
    parameter int REG_ADDR_W    = pipe_ctrl_pkg::REG_ADDR_W,
    parameter int FLUSH_CYCLES  = 1,
    parameter int MC_MAX_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_uses_rs1,
    input  logic                  id_uses_rs2,
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_branch_taken,
    input  logic                  ex_mc_start,
    input  logic                  mc_done,
    input  logic                  dmem_wait,
    output logic                  pc_write,
    output logic                  if_id_write,
    output logic                  id_ex_write,
    output logic                  if_id_flush,
    output logic                  id_ex_flush,
    output logic                  ex_mem_flush,
    output logic                  mc_timeout,
    output logic [1:0]            ctrl_state,
    output logic [31:0]           stall_cycles,
    output logic [31:0]           flush_events
);

    import pipe_ctrl_pkg::*;

    localparam int             WD_W         = $clog2(MC_MAX_CYCLES);
    localparam logic [WD_W-1:0] WD_LAST     = WD_W'(MC_MAX_CYCLES - 1);
    localparam logic [1:0]     FLUSH_RELOAD = 2'(FLUSH_CYCLES - 1);

    ctrl_state_e     state_q, state_d;
    logic [1:0]      flush_cnt_q, flush_cnt_d;
    logic [WD_W-1:0] wd_q, wd_d;
    logic            mc_timeout_q, mc_timeout_d;
    logic            load_use_s;
    logic            branch_accept_s;

    load_use_detect #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_load_use_detect (
        .id_valid    (id_valid),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_uses_rs1 (id_uses_rs1),
        .id_uses_rs2 (id_uses_rs2),
        .ex_mem_read (ex_mem_read),
        .ex_rd       (ex_rd),
        .hazard      (load_use_s)
    );

    // Output controls and next-state: dmem_wait > branch > multi-cycle > load-use
    always_comb begin
        pc_write        = 1'b1;
        if_id_write     = 1'b1;
        id_ex_write     = 1'b1;
        if_id_flush     = 1'b0;
        id_ex_flush     = 1'b0;
        ex_mem_flush    = 1'b0;
        state_d         = state_q;
        flush_cnt_d     = flush_cnt_q;
        wd_d            = wd_q;
        mc_timeout_d    = mc_timeout_q;
        branch_accept_s = 1'b0;

        if (reset) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_write = 1'b0;
        end else if (dmem_wait) begin
            // Whole pipe frozen; EX is held so other events re-evaluate later
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_write = 1'b0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (ex_branch_taken) begin
                        if_id_flush     = 1'b1;
                        id_ex_flush     = 1'b1;
                        branch_accept_s = 1'b1;
                        if (FLUSH_CYCLES > 1) begin
                            state_d     = ST_FLUSH;
                            flush_cnt_d = FLUSH_RELOAD;
                        end else begin
                            state_d     = ST_RUN;
                        end
                    end else if (ex_mc_start) begin
                        pc_write     = 1'b0;
                        if_id_write  = 1'b0;
                        id_ex_write  = 1'b0;
                        ex_mem_flush = 1'b1;
                        state_d      = ST_MC_WAIT;
                        wd_d         = {WD_W{1'b0}};
                    end else if (load_use_s) begin
                        pc_write    = 1'b0;
                        if_id_write = 1'b0;
                        id_ex_flush = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                ST_MC_WAIT: begin
                    if (mc_done) begin
                        state_d = ST_RUN;
                    end else if (wd_q == WD_LAST) begin
                        // Watchdog expiry: release as if done and flag it
                        mc_timeout_d = 1'b1;
                        state_d      = ST_RUN;
                    end else begin
                        pc_write     = 1'b0;
                        if_id_write  = 1'b0;
                        id_ex_write  = 1'b0;
                        ex_mem_flush = 1'b1;
                        wd_d         = wd_q + WD_W'(1);
                    end
                end
                ST_FLUSH: begin
                    if_id_flush = 1'b1;
                    if (ex_branch_taken) begin
                        id_ex_flush     = 1'b1;
                        branch_accept_s = 1'b1;
                        flush_cnt_d     = FLUSH_RELOAD;
                    end else if (flush_cnt_q > 2'd1) begin
                        flush_cnt_d = flush_cnt_q - 2'd1;
                    end else begin
                        flush_cnt_d = 2'd0;
                        state_d     = ST_RUN;
                    end
                end
                default: begin
                    state_d = ST_RUN;
                end
            endcase
        end
    end

    // Controller state registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_RUN;
            flush_cnt_q  <= 2'd0;
            wd_q         <= {WD_W{1'b0}};
            mc_timeout_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            flush_cnt_q  <= flush_cnt_d;
            wd_q         <= wd_d;
            mc_timeout_q <= mc_timeout_d;
        end
    end

    assign mc_timeout = mc_timeout_q;
    assign ctrl_state = state_q;

`ifdef PIPE_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
    logic [CNT_W-1:0] flush_events_q, flush_events_d;

    // Count stalled cycles and accepted branches; both wrap naturally
    always_comb begin
        if (!pc_write) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end else begin
            stall_cycles_d = stall_cycles_q;
        end
        if (branch_accept_s) begin
            flush_events_d = flush_events_q + 32'd1;
        end else begin
            flush_events_d = flush_events_q;
        end
    end

    // Performance counter registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cycles_q <= 32'd0;
            flush_events_q <= 32'd0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            flush_events_q <= flush_events_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_events = flush_events_q;
`else
    assign stall_cycles = 32'd0;
    assign flush_events = 32'd0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed self-checking bench for pipeline_hazard_ctrl (FLUSH_CYCLES=3,
// MC_MAX_CYCLES=8). Output pattern is {pc_w, if_id_w, id_ex_w, if_id_f,
// id_ex_f, ex_mem_f}.
module tb_pipeline_hazard_ctrl;

    localparam logic [5:0] P_RUN = 6'b111_000;
    localparam logic [5:0] P_LU  = 6'b001_010;
    localparam logic [5:0] P_BR  = 6'b111_110;
    localparam logic [5:0] P_FL  = 6'b111_100;
    localparam logic [5:0] P_MC  = 6'b000_001;
    localparam logic [5:0] P_FRZ = 6'b000_000;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid, id_uses_rs1, id_uses_rs2, ex_mem_read;
    logic [4:0]  id_rs1, id_rs2, ex_rd;
    logic        ex_branch_taken, ex_mc_start, mc_done, dmem_wait;
    logic        pc_write, if_id_write, id_ex_write;
    logic        if_id_flush, id_ex_flush, ex_mem_flush, mc_timeout;
    logic [1:0]  ctrl_state;
    logic [31:0] stall_cycles, flush_events;
    logic [5:0]  outs;

    int checks   = 0;
    int failures = 0;
    int exp_stall = 0;
    int exp_flush = 0;

    assign outs = {pc_write, if_id_write, id_ex_write, if_id_flush, id_ex_flush, ex_mem_flush};

    pipeline_hazard_ctrl #(
        .REG_ADDR_W    (5),
        .FLUSH_CYCLES  (3),
        .MC_MAX_CYCLES (8)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .id_valid        (id_valid),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_uses_rs1     (id_uses_rs1),
        .id_uses_rs2     (id_uses_rs2),
        .ex_mem_read     (ex_mem_read),
        .ex_rd           (ex_rd),
        .ex_branch_taken (ex_branch_taken),
        .ex_mc_start     (ex_mc_start),
        .mc_done         (mc_done),
        .dmem_wait       (dmem_wait),
        .pc_write        (pc_write),
        .if_id_write     (if_id_write),
        .id_ex_write     (id_ex_write),
        .if_id_flush     (if_id_flush),
        .id_ex_flush     (id_ex_flush),
        .ex_mem_flush    (ex_mem_flush),
        .mc_timeout      (mc_timeout),
        .ctrl_state      (ctrl_state),
        .stall_cycles    (stall_cycles),
        .flush_events    (flush_events)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic clear_inputs();
        id_valid = 1'b0; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0; ex_mem_read = 1'b0;
        id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
        ex_branch_taken = 1'b0; ex_mc_start = 1'b0; mc_done = 1'b0; dmem_wait = 1'b0;
    endtask

    task automatic set_load_use(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        ex_mem_read = 1'b1; ex_rd = rd; id_valid = 1'b1;
        id_uses_rs1 = 1'b1; id_uses_rs2 = 1'b1; id_rs1 = rs1; id_rs2 = rs2;
    endtask

    // Check the current cycle's outputs/state, then advance to just after the next edge
    task automatic cyc(input string tag, input logic [5:0] e_outs, input logic [1:0] e_state);
        #2;
        check_eq({tag, "/outs"}, {26'd0, outs}, {26'd0, e_outs});
        check_eq({tag, "/state"}, {30'd0, ctrl_state}, {30'd0, e_state});
        if (!e_outs[5]) exp_stall++;
        @(posedge clk);
        #1;
    endtask

    task automatic check_counters(input string tag);
`ifdef PIPE_PERF_CNT_EN
        check_eq({tag, "/stall_cycles"}, stall_cycles, exp_stall);
        check_eq({tag, "/flush_events"}, flush_events, exp_flush);
`else
        check_eq({tag, "/stall_cycles"}, stall_cycles, 32'd0);
        check_eq({tag, "/flush_events"}, flush_events, 32'd0);
`endif
    endtask

    initial begin
        reset = 1'b1;
        clear_inputs();
        #3;
        check_eq("rst/outs", {26'd0, outs}, 32'd0);
        check_eq("rst/state", {30'd0, ctrl_state}, 32'd0);
        check_eq("rst/timeout", {31'd0, mc_timeout}, 32'd0);
        check_counters("rst");
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Idle and load-use variants
        cyc("idle", P_RUN, 2'd0);
        set_load_use(5'd5, 5'd7, 5'd5); id_uses_rs1 = 1'b0;
        cyc("lu_rs2", P_LU, 2'd0);
        clear_inputs();
        cyc("lu_after", P_RUN, 2'd0);
        set_load_use(5'd9, 5'd9, 5'd3);
        cyc("lu_rs1", P_LU, 2'd0);
        set_load_use(5'd0, 5'd0, 5'd0);
        cyc("lu_x0", P_RUN, 2'd0);
        set_load_use(5'd5, 5'd5, 5'd5); id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
        cyc("lu_unused", P_RUN, 2'd0);
        set_load_use(5'd5, 5'd5, 5'd5); id_valid = 1'b0;
        cyc("lu_invalid", P_RUN, 2'd0);
        set_load_use(5'd5, 5'd5, 5'd5); ex_mem_read = 1'b0;
        cyc("lu_noload", P_RUN, 2'd0);
        clear_inputs();
        check_counters("after_lu");

        // Branch with 3-cycle flush
        ex_branch_taken = 1'b1; exp_flush++;
        cyc("br", P_BR, 2'd0);
        clear_inputs();
        cyc("fl1", P_FL, 2'd2);
        cyc("fl2", P_FL, 2'd2);
        cyc("fl_done", P_RUN, 2'd0);

        // Branch beats load-use and mc_start
        set_load_use(5'd4, 5'd4, 5'd4); ex_branch_taken = 1'b1; ex_mc_start = 1'b1; exp_flush++;
        cyc("br_pri", P_BR, 2'd0);
        clear_inputs();
        cyc("br_pri_fl1", P_FL, 2'd2);
        cyc("br_pri_fl2", P_FL, 2'd2);
        mc_done = 1'b1;
        cyc("done_in_run", P_RUN, 2'd0);
        clear_inputs();
        cyc("after_done_in_run", P_RUN, 2'd0);
        check_counters("after_br");

        // Multi-cycle op beating load-use, done after 5 wait cycles
        set_load_use(5'd6, 5'd6, 5'd1); ex_mc_start = 1'b1;
        cyc("mc_start", P_MC, 2'd0);
        clear_inputs();
        for (int i = 0; i < 5; i++) cyc("mc_wait", P_MC, 2'd1);
        mc_done = 1'b1;
        cyc("mc_done", P_RUN, 2'd1);
        clear_inputs();
        cyc("mc_after", P_RUN, 2'd0);
        check_eq("mc/timeout", {31'd0, mc_timeout}, 32'd0);
        check_counters("after_mc");

        // Watchdog: 8 stalled cycles then release and sticky timeout
        ex_mc_start = 1'b1;
        cyc("wd_start", P_MC, 2'd0);
        clear_inputs();
        for (int i = 0; i < 7; i++) cyc("wd_wait", P_MC, 2'd1);
        check_eq("wd/timeout_pre", {31'd0, mc_timeout}, 32'd0);
        cyc("wd_release", P_RUN, 2'd1);
        check_eq("wd/timeout_set", {31'd0, mc_timeout}, 32'd1);
        cyc("wd_after", P_RUN, 2'd0);
        cyc("wd_after2", P_RUN, 2'd0);
        check_eq("wd/timeout_sticky", {31'd0, mc_timeout}, 32'd1);

        // dmem_wait freezes MC_WAIT and its watchdog
        ex_mc_start = 1'b1;
        cyc("dm_start", P_MC, 2'd0);
        clear_inputs();
        cyc("dm_wait0", P_MC, 2'd1);
        cyc("dm_wait1", P_MC, 2'd1);
        dmem_wait = 1'b1; ex_branch_taken = 1'b1;
        for (int i = 0; i < 3; i++) cyc("dm_frozen", P_FRZ, 2'd1);
        clear_inputs();
        for (int i = 0; i < 5; i++) cyc("dm_wait_more", P_MC, 2'd1);
        cyc("dm_release", P_RUN, 2'd1);

        // Load-use plus branch together: branch wins; then freeze inside FLUSH
        set_load_use(5'd8, 5'd8, 5'd8); ex_branch_taken = 1'b1; exp_flush++;
        cyc("lu_br", P_BR, 2'd0);
        clear_inputs();
        cyc("lu_br_fl1", P_FL, 2'd2);
        dmem_wait = 1'b1;
        cyc("fl_frozen", P_FRZ, 2'd2);
        clear_inputs();
        cyc("lu_br_fl2", P_FL, 2'd2);
        cyc("lu_br_done", P_RUN, 2'd0);

        // Branch held off by dmem_wait, then branch restart inside FLUSH
        dmem_wait = 1'b1; ex_branch_taken = 1'b1;
        cyc("br_frozen", P_FRZ, 2'd0);
        dmem_wait = 1'b0; exp_flush++;
        cyc("br_late", P_BR, 2'd0);
        clear_inputs();
        cyc("rs_fl1", P_FL, 2'd2);
        ex_branch_taken = 1'b1; exp_flush++;
        cyc("br_restart", P_BR, 2'd2);
        clear_inputs();
        cyc("rs_fl2", P_FL, 2'd2);
        cyc("rs_fl3", P_FL, 2'd2);
        cyc("rs_done", P_RUN, 2'd0);
        check_counters("pre_reset");

        // Asynchronous reset between edges during FLUSH
        ex_branch_taken = 1'b1;
        cyc("ar_br", P_BR, 2'd0);
        clear_inputs();
        #2;
        check_eq("ar/state_flush", {30'd0, ctrl_state}, 32'd2);
        reset = 1'b1;
        #1;
        check_eq("ar/outs", {26'd0, outs}, 32'd0);
        check_eq("ar/state", {30'd0, ctrl_state}, 32'd0);
        check_eq("ar/timeout", {31'd0, mc_timeout}, 32'd0);
        exp_stall = 0;
        exp_flush = 0;
        check_counters("ar");
        @(posedge clk);
        #1;
        reset = 1'b0;
        cyc("post_rst", P_RUN, 2'd0);
        check_eq("post_rst/timeout", {31'd0, mc_timeout}, 32'd0);
        check_counters("post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
